// File: rtl/ptw_pkg.sv
// Shared types and AXI constants for the page-table-walk read responder.
package ptw_pkg;

  // Walk FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_t;

  // AXI read response encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Fixed AR attributes for a single 8-byte privileged data beat
  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B        = 3'b011;
  localparam logic [2:0] AXI_PROT_PRIV_DATA = 3'b001;

  // PTEs are 8-byte aligned
  localparam int unsigned PTE_ALIGN_BITS = 3;

endpackage

// File: rtl/ptw_axi_read_responder.sv
// Page-table-walk PTE fetch: one TLB request -> one single-beat AXI4 read ->
// one response pulse (or an immediate error for a bad address).
// Optional build macro: PTW_TIMEOUT_EN adds an R-channel wait limit with a
// drain of the late beat before new walks are accepted.
module ptw_axi_read_responder
  import ptw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 56,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ_VALID,
  input  logic [ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic                      FLUSH,
  output logic                      BUSY,
  output logic                      RSP_VALID,
  output logic [DATA_WIDTH-1:0]     RSP_DATA,
  output logic                      RSP_ERR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic [AXI_ID_WIDTH-1:0]   ARID,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [2:0]                ARPROT,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST
);

  localparam int unsigned TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                    state, state_n;
  logic                      arvalid_q, arvalid_n;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_n;
  logic                      rready_q, rready_n;
  logic                      rsp_valid_q, rsp_valid_n;
  logic                      rsp_err_q, rsp_err_n;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_n;
  logic                      busy_q, busy_n;
  logic                      abort_q, abort_n;
  logic                      addr_bad;
  logic                      beat_err;
  logic                      drain_hold;

`ifdef PTW_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_n;
  logic             drain_q, drain_n;

  // A pending drain keeps the block busy and blocks new walks
  assign drain_hold = drain_q;
`else
  logic unused_tmo;

  assign drain_hold = 1'b0;
  assign unused_tmo = ^TMO_LAST;
`endif

  // Request address must be PTE aligned and fit the physical address space
  assign addr_bad = (REQ_ADDR[PTE_ALIGN_BITS-1:0] != '0) ||
                    (REQ_ADDR[ADDR_WIDTH-1:AXI_ADDR_WIDTH] != '0);

  // SLVERR/DECERR or a beat that is not the last one is an access fault
  assign beat_err = (RRESP == AXI_RESP_SLVERR) || (RRESP == AXI_RESP_DECERR) || !RLAST;

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    arvalid_n   = arvalid_q;
    araddr_n    = araddr_q;
    rready_n    = rready_q;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_data_n  = rsp_data_q;
    abort_n     = abort_q;
    busy_n      = 1'b0;
`ifdef PTW_TIMEOUT_EN
    tmo_cnt_n   = tmo_cnt_q;
    drain_n     = drain_q;
`endif

    unique case (state)
      IDLE: begin
        abort_n = 1'b0;
`ifdef PTW_TIMEOUT_EN
        // Swallow the late beat of a timed-out read
        if (drain_q && RVALID && rready_q) begin
          rready_n = 1'b0;
          drain_n  = 1'b0;
        end
`endif
        if (REQ_VALID && !FLUSH && !drain_hold) begin
          if (addr_bad) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_data_n  = '0;
          end else begin
            state_n   = AR;
            arvalid_n = 1'b1;
            araddr_n  = REQ_ADDR[AXI_ADDR_WIDTH-1:0];
          end
        end
      end

      AR: begin
        if (FLUSH) abort_n = 1'b1;
        if (arvalid_q && ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = R;
`ifdef PTW_TIMEOUT_EN
          tmo_cnt_n = '0;
`endif
        end
      end

      R: begin
        if (RVALID && rready_q) begin
          rready_n = 1'b0;
          if (abort_q || FLUSH) begin
            state_n = IDLE;
          end else begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = beat_err;
            rsp_data_n  = beat_err ? '0 : RDATA;
          end
        end else begin
          if (FLUSH) abort_n = 1'b1;
`ifdef PTW_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            drain_n = 1'b1;
            if (abort_q || FLUSH) begin
              state_n = IDLE;
            end else begin
              state_n     = RESP;
              rsp_valid_n = 1'b1;
              rsp_err_n   = 1'b1;
              rsp_data_n  = '0;
            end
          end else begin
            tmo_cnt_n = tmo_cnt_q + 16'd1;
          end
`endif
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef PTW_TIMEOUT_EN
    busy_n = (state_n != IDLE) || drain_n;
`else
    busy_n = (state_n != IDLE);
`endif
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
`ifdef PTW_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      drain_q     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      arvalid_q   <= arvalid_n;
      araddr_q    <= araddr_n;
      rready_q    <= rready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_err_q   <= rsp_err_n;
      rsp_data_q  <= rsp_data_n;
      busy_q      <= busy_n;
      abort_q     <= abort_n;
`ifdef PTW_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_n;
      drain_q     <= drain_n;
`endif
    end
  end

  // A flush landing on the response cycle cancels the pulse
  assign RSP_VALID = rsp_valid_q && !FLUSH;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_DATA  = rsp_data_q;
  assign BUSY      = busy_q;
  assign ARVALID   = arvalid_q;
  assign ARADDR    = araddr_q;
  assign RREADY    = rready_q;

  // Fixed single-beat read attributes
  assign ARID    = AXI_ID_WIDTH'(AXI_ID);
  assign ARLEN   = 8'd0;
  assign ARSIZE  = AXI_SIZE_8B;
  assign ARBURST = AXI_BURST_INCR;
  assign ARPROT  = AXI_PROT_PRIV_DATA;

endmodule
